fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of the sync FIFO between two producers (src0, src1),
//  e.g. the UART-RX command path and the pattern/fill generator. Round-robin grant

---
 rtl/fifo_ctrl_pkg.sv | 23 ++
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/arb_rr_pick.sv | 20 ++
 rtl/fifo_wr_arbiter.sv | 115 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO-controller definitions: write-arbiter state encoding and UART command bytes.
// The grant state encoding doubles as the one-hot grant vector {src1,src0}.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_t;

    localparam logic [7:0] CMD_WRITE = 8'h77;
    localparam logic [7:0] CMD_READ  = 8'h72;

    // One-hot pick {src1,src0} to the state that serves it; no pick means IDLE.
    function automatic arb_state_t grant_to_state(input logic [1:0] pick);
        case (pick)
            2'b01:   return GRANT0;
            2'b10:   return GRANT1;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-write handshake bundle for fifo_wr_arbiter.
// master = producers plus FIFO side (drives valids, data, full); slave = the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int DATA_BITS = 8
);
    logic                 src0_valid_in;
    logic [DATA_BITS-1:0] src0_data_in;
    logic                 src0_ready_out;
    logic                 src1_valid_in;
    logic [DATA_BITS-1:0] src1_data_in;
    logic                 src1_ready_out;
    logic                 fifo_full_in;
    logic                 fifo_wr_en;
    logic [DATA_BITS-1:0] fifo_wr_data_out;
    logic [1:0]           grant_out;

    modport master (
        output src0_valid_in, src0_data_in, src1_valid_in, src1_data_in, fifo_full_in,
        input  src0_ready_out, src1_ready_out, fifo_wr_en, fifo_wr_data_out, grant_out
    );

    modport slave (
        input  src0_valid_in, src0_data_in, src1_valid_in, src1_data_in, fifo_full_in,
        output src0_ready_out, src1_ready_out, fifo_wr_en, fifo_wr_data_out, grant_out
    );
endinterface

// File: rtl/arb_rr_pick.sv
// Two-way round-robin pick: on a tie the source that was NOT served last wins.
// Result is one-hot {src1,src0}; 00 when neither source is valid.
module arb_rr_pick (
    input  logic       v0,
    input  logic       v1,
    input  logic       last_grant,
    output logic [1:0] grant
);
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        grant = 2'b00;
        if (v0 && v1) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (v0) begin
            grant = 2'b01;
        end else if (v1) begin
            grant = 2'b10;
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the FIFO write port between two producers.
// Define FIFO_WR_ARB_STATS_EN to add 16-bit per-source accepted-beat counters.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int MAX_BURST  = 4,
    parameter int BURST_BITS = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    fifo_wr_arbiter_if.slave   bus
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]        src0_count_out,
    output logic [15:0]        src1_count_out
`endif
);

    localparam logic [BURST_BITS-1:0] BURST_LAST = BURST_BITS'(MAX_BURST - 1);

    arb_state_t            state, state_nxt;
    logic [BURST_BITS-1:0] burst_cnt, burst_nxt;
    logic                  last_grant, last_nxt;

    logic                  cur_src;
    logic                  granted_valid;
    logic                  pick_last;
    logic [1:0]            pick;
    logic [DATA_BITS-1:0]  wr_data;

    // In a grant state the pick is evaluated as if the current source had just been served,
    // which yields both the end-of-burst hand-over and the release-on-idle decision.
    assign cur_src       = (state == GRANT1);
    assign granted_valid = cur_src ? bus.src1_valid_in : bus.src0_valid_in;
    assign pick_last     = (state == IDLE) ? last_grant : cur_src;

    arb_rr_pick u_pick (
        .v0         (bus.src0_valid_in),
        .v1         (bus.src1_valid_in),
        .last_grant (pick_last),
        .grant      (pick)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= burst_nxt;
            last_grant <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        last_nxt  = last_grant;
        case (state)
            IDLE: state_nxt = grant_to_state(pick);
            GRANT0, GRANT1: begin
                if (!granted_valid) begin
                    burst_nxt = '0;
                    last_nxt  = cur_src;
                    state_nxt = grant_to_state(pick);
                end else if (!bus.fifo_full_in) begin
                    if (burst_cnt == BURST_LAST) begin
                        burst_nxt = '0;
                        last_nxt  = cur_src;
                        state_nxt = grant_to_state(pick);
                    end else begin
                        burst_nxt = burst_cnt + BURST_BITS'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend on state only (plus same-cycle passthrough), so reset forces them to zero.
    always_comb begin
        bus.src0_ready_out = (state == GRANT0) && !bus.fifo_full_in;
        bus.src1_ready_out = (state == GRANT1) && !bus.fifo_full_in;
        bus.fifo_wr_en     = (bus.src0_ready_out && bus.src0_valid_in) ||
                             (bus.src1_ready_out && bus.src1_valid_in);
        wr_data = '0;
        if (bus.src0_ready_out && bus.src0_valid_in) begin
            wr_data = bus.src0_data_in;
        end else if (bus.src1_ready_out && bus.src1_valid_in) begin
            wr_data = bus.src1_data_in;
        end
        bus.fifo_wr_data_out = wr_data;
        bus.grant_out        = state;
    end

`ifdef FIFO_WR_ARB_STATS_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            src0_count_out <= '0;
            src1_count_out <= '0;
        end else begin
            if (bus.src0_ready_out && bus.src0_valid_in) begin
                src0_count_out <= src0_count_out + 16'd1;
            end
            if (bus.src1_ready_out && bus.src1_valid_in) begin
                src1_count_out <= src1_count_out + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against
// a cycle-level behavioural model. Define FIFO_WR_ARB_STATS_EN to also exercise the counters.
module tb_fifo_wr_arbiter;

    localparam int DATA_BITS  = 8;
    localparam int MAX_BURST  = 4;
    localparam int BURST_BITS = 3;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    fifo_wr_arbiter_if #(.DATA_BITS(DATA_BITS)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] src0_count_out;
    logic [15:0] src1_count_out;
`endif

    fifo_wr_arbiter #(
        .DATA_BITS  (DATA_BITS),
        .MAX_BURST  (MAX_BURST),
        .BURST_BITS (BURST_BITS)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .bus            (bus)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .src0_count_out (src0_count_out),
        .src1_count_out (src1_count_out)
`endif
    );

    typedef struct {
        logic [1:0]  grant;
        logic        rdy0;
        logic        rdy1;
        logic        wr_en;
        logic [15:0] cnt0;
        logic [15:0] cnt1;
    } cyc_exp_t;

    typedef struct {
        int         src;
        logic [7:0] data;
    } wr_exp_t;

    cyc_exp_t cyc_q[$];
    wr_exp_t  wr_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    bit running  = 0;

    // Reference model: who owns the port, beats served in this burst, who was served last.
    int          owner = -1;
    int          beats = 0;
    int          last  = 1;
    logic [15:0] m_cnt[2];

    // Producers: a pending byte is held on the bus until the model says it was taken.
    bit         pend[2];
    logic [7:0] cur[2];
    logic [7:0] next_byte[2];
    bit         rand_data = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gen_byte(input int k);
        logic [7:0] b;
        if (rand_data) begin
            b = 8'($urandom);
        end else begin
            b = next_byte[k];
            next_byte[k] = next_byte[k] + 8'd1;
        end
        return b;
    endfunction

    // One clock cycle: present producer bytes, predict the cycle, then advance past the edge.
    task automatic step(input bit want0, input bit want1, input bit full, input bit rst);
        bit       want[2];
        bit       acc[2];
        cyc_exp_t e;
        int       k;
        int       o;
        want = '{want0, want1};
        acc  = '{0, 0};
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && want[i]) begin
                pend[i] = 1;
                cur[i]  = gen_byte(i);
            end
        end
        rst_in            = rst;
        bus.fifo_full_in  = full;
        bus.src0_valid_in = pend[0];
        bus.src1_valid_in = pend[1];
        bus.src0_data_in  = pend[0] ? cur[0] : 8'($urandom);
        bus.src1_data_in  = pend[1] ? cur[1] : 8'($urandom);

        e = '{grant: 2'b00, rdy0: 1'b0, rdy1: 1'b0, wr_en: 1'b0, cnt0: m_cnt[0], cnt1: m_cnt[1]};
        if (rst) begin
            owner = -1; beats = 0; last = 1;
            m_cnt[0] = 16'd0; m_cnt[1] = 16'd0;
            e.cnt0 = 16'd0; e.cnt1 = 16'd0;
        end else if (owner < 0) begin
            if (pend[0] && pend[1]) owner = 1 - last;
            else if (pend[0])       owner = 0;
            else if (pend[1])       owner = 1;
        end else begin
            k = owner;
            o = 1 - owner;
            e.grant = (k == 0) ? 2'b01 : 2'b10;
            if (k == 0) e.rdy0 = !full; else e.rdy1 = !full;
            if (!pend[k]) begin
                beats = 0;
                last  = k;
                owner = pend[o] ? o : -1;
            end else if (!full) begin
                acc[k] = 1;
                beats++;
                if (beats == MAX_BURST) begin
                    beats = 0;
                    last  = k;
                    if (pend[o]) owner = o;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                e.wr_en = 1'b1;
                wr_q.push_back('{src: i, data: cur[i]});
                m_cnt[i] = m_cnt[i] + 16'd1;
                pend[i]  = 0;
            end
            if (rst) pend[i] = 0;
        end
        cyc_q.push_back(e);
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset(input int n, input bit want0, input bit want1);
        for (int i = 0; i < n; i++) step(want0, want1, 1'b0, 1'b1);
        next_byte[0] = 8'h00;
        next_byte[1] = 8'h80;
    endtask

    // Monitor: compare every cycle on the falling edge, away from the active edge.
    initial begin
        cyc_exp_t e;
        wr_exp_t  w;
        forever begin
            @(negedge clk_in);
            if (running) begin
                if (cyc_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL cycle_record: got none expected one at %0t", $time);
                end else begin
                    e = cyc_q.pop_front();
                    check("grant_out", 32'(bus.grant_out), 32'(e.grant));
                    check("src0_ready", 32'(bus.src0_ready_out), 32'(e.rdy0));
                    check("src1_ready", 32'(bus.src1_ready_out), 32'(e.rdy1));
                    check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(e.wr_en));
`ifdef FIFO_WR_ARB_STATS_EN
                    check("src0_count", 32'(src0_count_out), 32'(e.cnt0));
                    check("src1_count", 32'(src1_count_out), 32'(e.cnt1));
`endif
                    if (bus.fifo_wr_en === 1'b1) begin
                        if (wr_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL write_expected: got write 0x%0h expected none at %0t",
                                     bus.fifo_wr_data_out, $time);
                        end else begin
                            w = wr_q.pop_front();
                            check("wr_data", 32'(bus.fifo_wr_data_out), 32'(w.data));
                            check("wr_source", 32'(bus.grant_out), (w.src == 0) ? 32'd1 : 32'd2);
                        end
                    end else begin
                        check("idle_wr_data", 32'(bus.fifo_wr_data_out), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        bus.src0_valid_in = 1'b0;
        bus.src1_valid_in = 1'b0;
        bus.src0_data_in  = '0;
        bus.src1_data_in  = '0;
        bus.fifo_full_in  = 1'b0;
        m_cnt[0] = 16'd0; m_cnt[1] = 16'd0;
        pend[0] = 0; pend[1] = 0;
        @(posedge clk_in);
        #1;
        running = 1;

        // Reset with both producers valid, then round-robin bursts 4/4/4 without bubbles.
        do_reset(3, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Single producer: ten in-order bytes after one arbitration cycle.
        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 1'b0, 1'b0);

        // Stall mid-burst: two beats, three full cycles, then the remaining two beats.
        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a src1 burst; src0 must win first afterwards.
        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)  step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with back-pressure and occasional resets.
        rand_data = 1;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
        end
        rand_data = 0;

`ifdef FIFO_WR_ARB_STATS_EN
        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 301; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && m_cnt[1] != 16'd5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("src0_count_300", 32'(src0_count_out), 32'd300);
        check("src1_count_5", 32'(src1_count_out), 32'd5);

        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 65537; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("src1_count_wrap", 32'(src1_count_out), 32'd0);
        check("src0_count_idle", 32'(src0_count_out), 32'd0);
`endif

        step(1'b0, 1'b0, 1'b0, 1'b0);
        running = 0;
        check("writes_outstanding", 32'(wr_q.size()), 32'd0);
        check("cycles_outstanding", 32'(cyc_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
